// File: rtl/core_pkg.sv
// ============================================================================
// Module  : core_pkg
// Brief   : Shared core widths and the integer reservation-station entry type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;
    localparam int RS_DEPTH = 4;
    localparam int DATA_W   = 64;
    localparam int TAG_W    = 6;
    localparam int OPC_W    = 7;
    localparam int RS_IDX_W = $clog2(RS_DEPTH);

    typedef struct packed {
        logic              busy;
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] a_val;
        logic [DATA_W-1:0] b_val;
        logic [TAG_W-1:0]  a_tag;
        logic [TAG_W-1:0]  b_tag;
        logic              a_rdy;
        logic              b_rdy;
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  tag;
    } rs_entry_t;
endpackage

`default_nettype wire

// File: rtl/rs_integer_if.sv
// ============================================================================
// Module  : rs_integer_if
// Brief   : Dispatch, CDB and issue signals around the integer reservation station.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rs_integer_if;
    import core_pkg::*;

    logic              valid_dispatch2rsint;
    logic [OPC_W-1:0]  opcode_dispatch2rsint;
    logic [DATA_W-1:0] a_val_dispatch2rsint;
    logic [DATA_W-1:0] b_val_dispatch2rsint;
    logic [TAG_W-1:0]  a_tag_dispatch2rsint;
    logic [TAG_W-1:0]  b_tag_dispatch2rsint;
    logic              a_rdy_dispatch2rsint;
    logic              b_rdy_dispatch2rsint;
    logic [TAG_W-1:0]  rd_dispatch2rsint;
    logic [TAG_W-1:0]  tag_dispatch2rsint;
    logic              stop_rsint2dispatch;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_result;

    logic              valid_in;
    logic [OPC_W-1:0]  opcode_in;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [TAG_W-1:0]  rd_in;
    logic [TAG_W-1:0]  tag_in;
    logic              stop_int2rsint;

    // Environment side: dispatch, CDB and integer unit.
    modport master (
        output valid_dispatch2rsint, opcode_dispatch2rsint,
               a_val_dispatch2rsint, b_val_dispatch2rsint,
               a_tag_dispatch2rsint, b_tag_dispatch2rsint,
               a_rdy_dispatch2rsint, b_rdy_dispatch2rsint,
               rd_dispatch2rsint, tag_dispatch2rsint,
               cdb_valid, cdb_tag, cdb_result, stop_int2rsint,
        input  stop_rsint2dispatch,
               valid_in, opcode_in, a_in, b_in, rd_in, tag_in
    );

    // Reservation-station side.
    modport slave (
        input  valid_dispatch2rsint, opcode_dispatch2rsint,
               a_val_dispatch2rsint, b_val_dispatch2rsint,
               a_tag_dispatch2rsint, b_tag_dispatch2rsint,
               a_rdy_dispatch2rsint, b_rdy_dispatch2rsint,
               rd_dispatch2rsint, tag_dispatch2rsint,
               cdb_valid, cdb_tag, cdb_result, stop_int2rsint,
        output stop_rsint2dispatch,
               valid_in, opcode_in, a_in, b_in, rd_in, tag_in
    );
endinterface

`default_nettype wire

// File: rtl/rs_prio_enc.sv
// ============================================================================
// Module  : rs_prio_enc
// Brief   : Index of the lowest set request bit, plus a found flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_prio_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [WIDTH-1:0] req,
    output logic      [IDX_W-1:0] idx,
    output logic                  found
);
    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/rs_integer.sv
// ============================================================================
// Module  : rs_integer
// Brief   : Four-entry integer reservation station with CDB wakeup and in-order-by-slot issue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_integer
    import core_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   res_n,
    rs_integer_if.slave bus
);
    rs_entry_t r_rs [RS_DEPTH];
    rs_entry_t w_rs_next [RS_DEPTH];
    rs_entry_t w_disp_entry;

    logic [RS_DEPTH-1:0] w_busy;
    logic [RS_DEPTH-1:0] w_cand;
    logic [RS_IDX_W-1:0] w_alloc_idx;
    logic [RS_IDX_W-1:0] w_issue_idx;
    logic                w_alloc_found;
    logic                w_issue_found;
    logic                w_do_dispatch;
    logic                w_do_issue;
    logic                w_a_bypass;
    logic                w_b_bypass;

    logic              r_valid_in;
    logic [OPC_W-1:0]  r_opcode_in;
    logic [DATA_W-1:0] r_a_in;
    logic [DATA_W-1:0] r_b_in;
    logic [TAG_W-1:0]  r_rd_in;
    logic [TAG_W-1:0]  r_tag_in;

    for (genvar g = 0; g < RS_DEPTH; g++) begin : g_status
        assign w_busy[g] = r_rs[g].busy;
        assign w_cand[g] = r_rs[g].busy & r_rs[g].a_rdy & r_rs[g].b_rdy;
    end

    rs_prio_enc #(.WIDTH(RS_DEPTH), .IDX_W(RS_IDX_W)) u_alloc_enc (
        .req   (~w_busy),
        .idx   (w_alloc_idx),
        .found (w_alloc_found)
    );

    rs_prio_enc #(.WIDTH(RS_DEPTH), .IDX_W(RS_IDX_W)) u_issue_enc (
        .req   (w_cand),
        .idx   (w_issue_idx),
        .found (w_issue_found)
    );

    assign bus.stop_rsint2dispatch = &w_busy;
    assign w_do_dispatch = bus.valid_dispatch2rsint & ~(&w_busy) & w_alloc_found;
    assign w_do_issue    = w_issue_found & ~bus.stop_int2rsint;

    // An operand arriving on the CDB in the dispatch cycle is captured directly.
    assign w_a_bypass = bus.cdb_valid & ~bus.a_rdy_dispatch2rsint
                      & (bus.a_tag_dispatch2rsint == bus.cdb_tag);
    assign w_b_bypass = bus.cdb_valid & ~bus.b_rdy_dispatch2rsint
                      & (bus.b_tag_dispatch2rsint == bus.cdb_tag);

    always_comb begin
        w_disp_entry.busy   = 1'b1;
        w_disp_entry.opcode = bus.opcode_dispatch2rsint;
        w_disp_entry.a_val  = w_a_bypass ? bus.cdb_result : bus.a_val_dispatch2rsint;
        w_disp_entry.b_val  = w_b_bypass ? bus.cdb_result : bus.b_val_dispatch2rsint;
        w_disp_entry.a_tag  = bus.a_tag_dispatch2rsint;
        w_disp_entry.b_tag  = bus.b_tag_dispatch2rsint;
        w_disp_entry.a_rdy  = bus.a_rdy_dispatch2rsint | w_a_bypass;
        w_disp_entry.b_rdy  = bus.b_rdy_dispatch2rsint | w_b_bypass;
        w_disp_entry.rd     = bus.rd_dispatch2rsint;
        w_disp_entry.tag    = bus.tag_dispatch2rsint;
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_rs_next[i] = r_rs[i];
            if (r_rs[i].busy && bus.cdb_valid) begin
                if (!r_rs[i].a_rdy && r_rs[i].a_tag == bus.cdb_tag) begin
                    w_rs_next[i].a_rdy = 1'b1;
                    w_rs_next[i].a_val = bus.cdb_result;
                end
                if (!r_rs[i].b_rdy && r_rs[i].b_tag == bus.cdb_tag) begin
                    w_rs_next[i].b_rdy = 1'b1;
                    w_rs_next[i].b_val = bus.cdb_result;
                end
            end
            if (w_do_issue && w_issue_idx == RS_IDX_W'(i)) begin
                w_rs_next[i].busy = 1'b0;
            end
            // Allocation only targets a free slot, so it never collides with the issued one.
            if (w_do_dispatch && w_alloc_idx == RS_IDX_W'(i)) begin
                w_rs_next[i] = w_disp_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_rs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_rs[i] <= w_rs_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_valid_in  <= 1'b0;
            r_opcode_in <= '0;
            r_a_in      <= '0;
            r_b_in      <= '0;
            r_rd_in     <= '0;
            r_tag_in    <= '0;
        end else begin
            r_valid_in <= w_do_issue;
            if (w_do_issue) begin
                r_opcode_in <= r_rs[w_issue_idx].opcode;
                r_a_in      <= r_rs[w_issue_idx].a_val;
                r_b_in      <= r_rs[w_issue_idx].b_val;
                r_rd_in     <= r_rs[w_issue_idx].rd;
                r_tag_in    <= r_rs[w_issue_idx].tag;
            end
        end
    end

    assign bus.valid_in  = r_valid_in;
    assign bus.opcode_in = r_opcode_in;
    assign bus.a_in      = r_a_in;
    assign bus.b_in      = r_b_in;
    assign bus.rd_in     = r_rd_in;
    assign bus.tag_in    = r_tag_in;
endmodule

`default_nettype wire

// File: tb/tb_rs_integer.sv
// ============================================================================
// Module  : tb_rs_integer
// Brief   : Self-checking bench: directed table, corner sequences, randomized model run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_integer;
    import core_pkg::*;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    rs_integer_if bus();

    rs_integer dut (.clk(clk), .res_n(res_n), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_disp;
        bus.valid_dispatch2rsint  = 1'b0;
        bus.opcode_dispatch2rsint = '0;
        bus.a_val_dispatch2rsint  = '0;
        bus.b_val_dispatch2rsint  = '0;
        bus.a_tag_dispatch2rsint  = '0;
        bus.b_tag_dispatch2rsint  = '0;
        bus.a_rdy_dispatch2rsint  = 1'b0;
        bus.b_rdy_dispatch2rsint  = 1'b0;
        bus.rd_dispatch2rsint     = '0;
        bus.tag_dispatch2rsint    = '0;
    endtask

    task automatic idle_cdb;
        bus.cdb_valid  = 1'b0;
        bus.cdb_tag    = '0;
        bus.cdb_result = '0;
    endtask

    task automatic drive_disp(input logic [6:0] opc, input logic [63:0] a, input logic [63:0] b,
                              input logic ar, input logic br, input logic [5:0] at,
                              input logic [5:0] bt, input logic [5:0] rd, input logic [5:0] tg);
        bus.valid_dispatch2rsint  = 1'b1;
        bus.opcode_dispatch2rsint = opc;
        bus.a_val_dispatch2rsint  = a;
        bus.b_val_dispatch2rsint  = b;
        bus.a_rdy_dispatch2rsint  = ar;
        bus.b_rdy_dispatch2rsint  = br;
        bus.a_tag_dispatch2rsint  = at;
        bus.b_tag_dispatch2rsint  = bt;
        bus.rd_dispatch2rsint     = rd;
        bus.tag_dispatch2rsint    = tg;
    endtask

    task automatic drive_cdb(input logic [5:0] tg, input logic [63:0] res);
        bus.cdb_valid  = 1'b1;
        bus.cdb_tag    = tg;
        bus.cdb_result = res;
    endtask

    task automatic do_reset;
        idle_disp();
        idle_cdb();
        bus.stop_int2rsint = 1'b0;
        res_n = 1'b0;
        tick();
        tick();
        res_n = 1'b1;
    endtask

    // Reference model: a pool of four slots, scanned lowest index first.
    logic        m_busy [RS_DEPTH];
    logic [6:0]  m_opc  [RS_DEPTH];
    logic [63:0] m_a    [RS_DEPTH];
    logic [63:0] m_b    [RS_DEPTH];
    logic        m_ar   [RS_DEPTH];
    logic        m_br   [RS_DEPTH];
    logic [5:0]  m_at   [RS_DEPTH];
    logic [5:0]  m_bt   [RS_DEPTH];
    logic [5:0]  m_rd   [RS_DEPTH];
    logic [5:0]  m_tg   [RS_DEPTH];
    logic        mo_valid;
    logic [6:0]  mo_opc;
    logic [63:0] mo_a, mo_b;
    logic [5:0]  mo_rd, mo_tag;

    function automatic logic model_full();
        int n = 0;
        for (int i = 0; i < RS_DEPTH; i++) if (m_busy[i]) n++;
        return n == RS_DEPTH;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < RS_DEPTH; i++) begin
            m_busy[i] = 0; m_ar[i] = 0; m_br[i] = 0;
        end
        mo_valid = 0; mo_opc = 0; mo_a = 0; mo_b = 0; mo_rd = 0; mo_tag = 0;
    endtask

    task automatic model_edge;
        int  cand = -1;
        int  slot = -1;
        logic full = model_full();
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (m_busy[i] && m_ar[i] && m_br[i]) cand = i;
            if (!m_busy[i]) slot = i;
        end
        mo_valid = (cand >= 0) && !bus.stop_int2rsint;
        if (mo_valid) begin
            mo_opc = m_opc[cand]; mo_a = m_a[cand]; mo_b = m_b[cand];
            mo_rd = m_rd[cand];   mo_tag = m_tg[cand];
        end
        if (bus.cdb_valid) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (m_busy[i] && !m_ar[i] && m_at[i] == bus.cdb_tag) begin m_ar[i] = 1; m_a[i] = bus.cdb_result; end
                if (m_busy[i] && !m_br[i] && m_bt[i] == bus.cdb_tag) begin m_br[i] = 1; m_b[i] = bus.cdb_result; end
            end
        end
        if (mo_valid) m_busy[cand] = 0;
        if (bus.valid_dispatch2rsint && !full && slot >= 0) begin
            m_busy[slot] = 1;
            m_opc[slot] = bus.opcode_dispatch2rsint;
            m_at[slot] = bus.a_tag_dispatch2rsint;
            m_bt[slot] = bus.b_tag_dispatch2rsint;
            m_rd[slot] = bus.rd_dispatch2rsint;
            m_tg[slot] = bus.tag_dispatch2rsint;
            m_ar[slot] = bus.a_rdy_dispatch2rsint;
            m_br[slot] = bus.b_rdy_dispatch2rsint;
            m_a[slot]  = bus.a_val_dispatch2rsint;
            m_b[slot]  = bus.b_val_dispatch2rsint;
            if (bus.cdb_valid && !m_ar[slot] && m_at[slot] == bus.cdb_tag) begin m_ar[slot] = 1; m_a[slot] = bus.cdb_result; end
            if (bus.cdb_valid && !m_br[slot] && m_bt[slot] == bus.cdb_tag) begin m_br[slot] = 1; m_b[slot] = bus.cdb_result; end
        end
    endtask

    typedef struct {
        logic [63:0] a, b;
        logic        a_rdy, b_rdy;
        logic [5:0]  a_tag, b_tag, rd, tag;
        int          gap;       // -1: no broadcast; 0: same cycle as dispatch; n: n edges later
        logic [5:0]  cdb_tag;
        logic [63:0] cdb_res;
        logic [63:0] exp_a, exp_b;
        int          exp_lat;   // -1: never issues
    } vec_t;

    vec_t vt [6];

    initial begin
        int lat, n_issue, cnt;
        logic [63:0] got_a, got_b;
        logic [6:0]  got_opc;
        logic [5:0]  got_rd, got_tag;

        vt[0] = '{64'd5, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd9, 6'd3, -1, 6'd0, 64'd0, 64'd5, 64'd7, 1};
        vt[1] = '{64'd0, 64'd3, 1'b0, 1'b1, 6'd12, 6'd0, 6'd1, 6'd4, 2, 6'd12, 64'd100, 64'd100, 64'd3, 3};
        vt[2] = '{64'd0, 64'd8, 1'b0, 1'b1, 6'd20, 6'd0, 6'd2, 6'd5, 0, 6'd20, 64'd55, 64'd55, 64'd8, 1};
        vt[3] = '{64'd11, 64'd0, 1'b1, 1'b0, 6'd0, 6'd7, 6'd3, 6'd6, 1, 6'd7,
                  64'hDEAD_BEEF_0123_4567, 64'd11, 64'hDEAD_BEEF_0123_4567, 2};
        vt[4] = '{64'd0, 64'd0, 1'b0, 1'b0, 6'd9, 6'd9, 6'd4, 6'd7, 1, 6'd9,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2};
        vt[5] = '{64'd1, 64'd2, 1'b0, 1'b1, 6'd13, 6'd0, 6'd5, 6'd8, 1, 6'd14, 64'd99, 64'd0, 64'd0, -1};

        do_reset();
        check("reset_valid_in", 64'(bus.valid_in), 64'd0);
        check("reset_a_in", bus.a_in, 64'd0);
        check("reset_stop", 64'(bus.stop_rsint2dispatch), 64'd0);

        // Directed table: single instruction, measured issue latency and fields.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            drive_disp(7'(8'h30 + v), vt[v].a, vt[v].b, vt[v].a_rdy, vt[v].b_rdy,
                       vt[v].a_tag, vt[v].b_tag, vt[v].rd, vt[v].tag);
            if (vt[v].gap == 0) drive_cdb(vt[v].cdb_tag, vt[v].cdb_res);
            tick();
            idle_disp();
            idle_cdb();
            lat = -1; n_issue = 0;
            got_a = 0; got_b = 0; got_opc = 0; got_rd = 0; got_tag = 0;
            for (int e = 1; e <= 6; e++) begin
                if (vt[v].gap == e) drive_cdb(vt[v].cdb_tag, vt[v].cdb_res);
                tick();
                idle_cdb();
                if (bus.valid_in) begin
                    n_issue++;
                    if (lat < 0) begin
                        lat = e; got_a = bus.a_in; got_b = bus.b_in;
                        got_opc = bus.opcode_in; got_rd = bus.rd_in; got_tag = bus.tag_in;
                    end
                end
            end
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(vt[v].exp_lat));
            check($sformatf("vec%0d_issue_count", v), 64'(n_issue), (vt[v].exp_lat < 0) ? 64'd0 : 64'd1);
            if (vt[v].exp_lat >= 0) begin
                check($sformatf("vec%0d_a_in", v), got_a, vt[v].exp_a);
                check($sformatf("vec%0d_b_in", v), got_b, vt[v].exp_b);
                check($sformatf("vec%0d_rd_in", v), 64'(got_rd), 64'(vt[v].rd));
                check($sformatf("vec%0d_tag_in", v), 64'(got_tag), 64'(vt[v].tag));
                check($sformatf("vec%0d_opcode_in", v), 64'(got_opc), 64'(8'h30 + v));
                if (v == 0) check("vec0_int_result", got_a + got_b, 64'd12);
            end
        end

        // Fill all four slots, reject a fifth, wake slot 2.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill%0d_stop_before", i), 64'(bus.stop_rsint2dispatch), 64'd0);
            drive_disp(7'h11, 64'(i + 1), 64'd50, 1'b0, 1'b1, 6'(32 + i), 6'd0, 6'(i), 6'(i));
            tick();
        end
        idle_disp();
        check("full_stop", 64'(bus.stop_rsint2dispatch), 64'd1);
        drive_disp(7'h22, 64'd1, 64'd1, 1'b1, 1'b1, 6'd0, 6'd0, 6'd40, 6'd40);
        tick();
        idle_disp();
        check("dropped_no_issue", 64'(bus.valid_in), 64'd0);
        drive_cdb(6'd34, 64'd77);
        tick();
        idle_cdb();
        check("wake_stop_held", 64'(bus.stop_rsint2dispatch), 64'd1);
        check("wake_no_issue_yet", 64'(bus.valid_in), 64'd0);
        tick();
        check("wake_issue_valid", 64'(bus.valid_in), 64'd1);
        check("wake_issue_tag", 64'(bus.tag_in), 64'd2);
        check("wake_issue_a", bus.a_in, 64'd77);
        check("wake_stop_drop", 64'(bus.stop_rsint2dispatch), 64'd0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (bus.valid_in) cnt++; end
        check("dropped_never_issued", 64'(cnt), 64'd0);

        // Integer unit stall holds the ready entry; release issues it once.
        do_reset();
        bus.stop_int2rsint = 1'b1;
        drive_disp(7'h05, 64'd21, 64'd22, 1'b1, 1'b1, 6'd0, 6'd0, 6'd11, 6'd10);
        tick();
        idle_disp();
        cnt = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.valid_in) cnt++; end
        check("stall_no_issue", 64'(cnt), 64'd0);
        check("stall_a_in_held", bus.a_in, 64'd0);
        bus.stop_int2rsint = 1'b0;
        tick();
        check("release_valid", 64'(bus.valid_in), 64'd1);
        check("release_tag", 64'(bus.tag_in), 64'd10);
        check("release_a", bus.a_in, 64'd21);
        tick();
        check("release_once", 64'(bus.valid_in), 64'd0);
        check("release_tag_held", 64'(bus.tag_in), 64'd10);

        // Asynchronous reset with three resident entries.
        do_reset();
        bus.stop_int2rsint = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_disp(7'h09, 64'(100 + i), 64'd1, 1'b1, 1'b1, 6'd0, 6'd0, 6'(i), 6'(i));
            tick();
        end
        idle_disp();
        bus.stop_int2rsint = 1'b0;
        tick();
        bus.stop_int2rsint = 1'b1;
        check("pre_reset_valid", 64'(bus.valid_in), 64'd1);
        check("pre_reset_a", bus.a_in, 64'd100);
        #1 res_n = 1'b0;
        #1;
        check("async_valid_in", 64'(bus.valid_in), 64'd0);
        check("async_a_in", bus.a_in, 64'd0);
        check("async_b_in", bus.b_in, 64'd0);
        check("async_opcode_rd_tag", {bus.opcode_in, bus.rd_in, bus.tag_in}, 64'd0);
        check("async_stop", 64'(bus.stop_rsint2dispatch), 64'd0);
        tick();
        res_n = 1'b1;
        bus.stop_int2rsint = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.valid_in) cnt++; end
        check("post_reset_no_issue", 64'(cnt), 64'd0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 6)
                drive_disp(7'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                           6'($urandom), 6'($urandom));
            else
                idle_disp();
            if ($urandom_range(0, 9) < 4) drive_cdb(6'($urandom_range(0, 7)), {$urandom, $urandom});
            else idle_cdb();
            bus.stop_int2rsint = ($urandom_range(0, 3) == 0);
            check($sformatf("rand%0d_stop", c), 64'(bus.stop_rsint2dispatch), 64'(model_full()));
            model_edge();
            tick();
            check($sformatf("rand%0d_ctl", c),
                  {44'd0, bus.valid_in, bus.opcode_in, bus.rd_in, bus.tag_in},
                  {44'd0, mo_valid, mo_opc, mo_rd, mo_tag});
            check($sformatf("rand%0d_a", c), bus.a_in, mo_a);
            check($sformatf("rand%0d_b", c), bus.b_in, mo_b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
